// File: rtl/mod_148_4_4_timer_ctrl.sv
// ---------------------------------------------------------------------------
// mod_148_4_4_timer_ctrl
//
// Purpose: synthesizable controller for the six PLCA timers (beacon,
// beacon_det, invalid_beacon, burst, to, append_commit). Each timer is a
// small IDLE/RUN/EXPIRED FSM with a down-counter. The counter is loaded
// from ceil(DUR_NS / CLK_PERIOD_NS), which is computed when the design is
// elaborated.
//
// Optional feature macro: TIMER_FAST_SIM_EN
//   When this macro is defined, the block gains a scale_sel input. If
//   scale_sel is 1 when a start is taken, the timer loads max(1, N>>4)
//   instead of N.
//
// Ports (bit map for all 6-bit vectors:
//   0 beacon, 1 beacon_det, 2 invalid_beacon, 3 burst, 4 to, 5 append_commit)
//   clk            in   block clock, rising edge
//   reset_n        in   synchronous active-low reset
//   start[5:0]     in   start/restart request per timer
//   stop[5:0]      in   abort request per timer
//   scale_sel      in   fast-sim reload select (TIMER_FAST_SIM_EN only)
//   timer_done     out  timer expired since its last start
//   timer_not_done out  timer running
//   expire_pulse   out  one-cycle strobe on the expiry edge
// ---------------------------------------------------------------------------

// One timer: state register, down-counter and registered expiry strobe.
module mod_148_4_4_timer_ctrl_unit #(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          stop,
    input  logic [CW-1:0] reload,
    output logic          done,
    output logic          not_done,
    output logic          pulse
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_EXP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    // start beats stop, and both beat the expiry step in the same cycle.
    // Because of this ordering, a collision never produces a pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (start) begin
            state_d = ST_RUN;
            cnt_d   = reload;
        end else if (stop) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (state_q == ST_RUN) begin
            if (cnt_q > CW'(1)) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                // The last RUN cycle expires here. The counter parks at
                // zero, so it can never underflow.
                state_d = ST_EXP;
                cnt_d   = '0;
                pulse_d = 1'b1;
            end
        end
    end

    assign done     = (state_q == ST_EXP);
    assign not_done = (state_q == ST_RUN);
    assign pulse    = pulse_q;

endmodule

module mod_148_4_4_timer_ctrl #(
    parameter int unsigned CLK_PERIOD_NS    = 40,
    parameter int unsigned BEACON_NS        = 2000,
    parameter int unsigned BEACON_DET_NS    = 2200,
    parameter int unsigned INVALID_BEACON_NS = 4000,
    parameter int unsigned BURST_NS         = 12800,
    parameter int unsigned TO_NS            = 3200,
    parameter int unsigned APPEND_COMMIT_NS = 2200,
    parameter int unsigned CW               = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] start,
    input  logic [5:0] stop,
`ifdef TIMER_FAST_SIM_EN
    input  logic       scale_sel,
`endif
    output logic [5:0] timer_done,
    output logic [5:0] timer_not_done,
    output logic [5:0] expire_pulse
);

    localparam int NUM_TIMERS = 6;

    // Computes ceil(dur/period). A zero duration is clamped to a reload of 1
    // so that every timer stays in RUN for at least one cycle.
    function automatic int unsigned calc_reload(input int unsigned dur_ns,
                                                input int unsigned per_ns);
        int unsigned n;
        n = (dur_ns + per_ns - 1) / per_ns;
        if (n == 0) n = 1;
        return n;
    endfunction

    localparam int unsigned N_TAB [NUM_TIMERS] = '{
        calc_reload(BEACON_NS,         CLK_PERIOD_NS),
        calc_reload(BEACON_DET_NS,     CLK_PERIOD_NS),
        calc_reload(INVALID_BEACON_NS, CLK_PERIOD_NS),
        calc_reload(BURST_NS,          CLK_PERIOD_NS),
        calc_reload(TO_NS,             CLK_PERIOD_NS),
        calc_reload(APPEND_COMMIT_NS,  CLK_PERIOD_NS)
    };

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_tmr
        localparam int unsigned N = N_TAB[i];

        if (64'(N) >= (64'd1 << CW)) begin : g_range_err
            $error("timer %0d reload %0d does not fit in CW=%0d bits", i, N, CW);
        end

        logic [CW-1:0] reload;
`ifdef TIMER_FAST_SIM_EN
        localparam int unsigned N_FAST = ((N >> 4) == 0) ? 1 : (N >> 4);
        // scale_sel only reaches the counter through the load path, so a
        // change during a run leaves the running count unaffected.
        assign reload = scale_sel ? CW'(N_FAST) : CW'(N);
`else
        assign reload = CW'(N);
`endif

        mod_148_4_4_timer_ctrl_unit #(.CW(CW)) u_unit (
            .clk      (clk),
            .reset_n  (reset_n),
            .start    (start[i]),
            .stop     (stop[i]),
            .reload   (reload),
            .done     (timer_done[i]),
            .not_done (timer_not_done[i]),
            .pulse    (expire_pulse[i])
        );
    end

endmodule

// File: tb/tb_mod_148_4_4_timer_ctrl.sv
module tb_mod_148_4_4_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] start;
    logic [5:0] stop;
`ifdef TIMER_FAST_SIM_EN
    logic       scale_sel;
`endif
    logic [5:0] timer_done;
    logic [5:0] timer_not_done;
    logic [5:0] expire_pulse;

    mod_148_4_4_timer_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .stop           (stop),
`ifdef TIMER_FAST_SIM_EN
        .scale_sel      (scale_sel),
`endif
        .timer_done     (timer_done),
        .timer_not_done (timer_not_done),
        .expire_pulse   (expire_pulse)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    // Each scoreboard entry records the edge and the bit at which an expiry
    // pulse is expected.
    typedef struct {
        int edge_no;
        int bit_idx;
    } exp_t;
    exp_t sb[$];

    // Reference reload values, worked out by hand from the default durations.
    localparam int N0 = 50, N1 = 55, N2 = 100, N3 = 320, N4 = 80, N5 = 55;

    // The monitor samples at the falling edge. Every pulse that appears is
    // popped from the scoreboard and compared with the entry.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int b = 0; b < 6; b++) begin
                if (expire_pulse[b] === 1'b1) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL pulse_unexpected: bit %0d at edge %0d, none expected", b, edge_cnt);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        if (e.edge_no !== edge_cnt || e.bit_idx !== b) begin
                            bad++;
                            $display("FAIL pulse_order: got bit %0d edge %0d, want bit %0d edge %0d",
                                     b, edge_cnt, e.bit_idx, e.edge_no);
                        end
                    end
                end
            end
            if (sb.size() > 0 && sb[0].edge_no < edge_cnt) begin
                exp_t e;
                e = sb.pop_front();
                total++;
                bad++;
                $display("FAIL pulse_missed: bit %0d expected at edge %0d, now %0d",
                         e.bit_idx, e.edge_no, edge_cnt);
            end
            total++;
            if ((timer_done & timer_not_done) !== 6'h00) begin
                bad++;
                $display("FAIL done_and_not_done: done=%h not_done=%h at edge %0d",
                         timer_done, timer_not_done, edge_cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = '0;
        stop    = '0;
`ifdef TIMER_FAST_SIM_EN
        scale_sel = 1'b0;
`endif
        tick_n(3);
        total++;
        if ({timer_done, timer_not_done, expire_pulse} !== 18'h0) begin
            bad++;
            $display("FAIL reset_state: done=%h not_done=%h pulse=%h want 0",
                     timer_done, timer_not_done, expire_pulse);
        end
        reset_n = 1'b1;
        mon_en  = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if ({timer_done, timer_not_done, expire_pulse} !== 18'h0) begin
                total++;
                bad++;
                $display("FAIL idle_quiet: done=%h not_done=%h pulse=%h at cycle %0d",
                         timer_done, timer_not_done, expire_pulse, i);
            end
        end
        total++;
        if ({timer_done, timer_not_done} !== 12'h0) begin
            bad++;
            $display("FAIL idle_end: done=%h not_done=%h want 0", timer_done, timer_not_done);
        end
    endtask

    task automatic test_single_expiry();
        int k;
        start = 6'b000001;
        tick();
        k = edge_cnt;
        start = '0;
        sb.push_back('{k + N0, 0});
        total++;
        if (timer_not_done[0] !== 1'b1 || timer_done[0] !== 1'b0) begin
            bad++;
            $display("FAIL single_start: not_done0=%b done0=%b want 1/0", timer_not_done[0], timer_done[0]);
        end
        tick_n(N0 - 1);
        total++;
        if (timer_not_done[0] !== 1'b1 || timer_done[0] !== 1'b0) begin
            bad++;
            $display("FAIL single_last_run: not_done0=%b done0=%b want 1/0", timer_not_done[0], timer_done[0]);
        end
        tick();
        total++;
        if (timer_done[0] !== 1'b1 || timer_not_done[0] !== 1'b0 || expire_pulse[0] !== 1'b1) begin
            bad++;
            $display("FAIL single_expiry: done0=%b not_done0=%b pulse0=%b want 1/0/1",
                     timer_done[0], timer_not_done[0], expire_pulse[0]);
        end
        tick_n(20);
        total++;
        if (timer_done[0] !== 1'b1 || expire_pulse[0] !== 1'b0) begin
            bad++;
            $display("FAIL single_hold: done0=%b pulse0=%b want 1/0", timer_done[0], expire_pulse[0]);
        end
        stop = 6'b000001;
        tick();
        stop = '0;
        total++;
        if (timer_done[0] !== 1'b0 || timer_not_done[0] !== 1'b0) begin
            bad++;
            $display("FAIL single_stop: done0=%b not_done0=%b want 0/0", timer_done[0], timer_not_done[0]);
        end
    endtask

    task automatic test_restart_concurrency();
        int k;
        start = 6'b011000;
        tick();
        k = edge_cnt;
        start = '0;
        // After the restart at k+40, bit 4 expires at k+120. Bit 3 expires at k+320.
        sb.push_back('{k + 40 + N4, 4});
        sb.push_back('{k + N3, 3});
        tick_n(39);
        start = 6'b010000;
        tick();
        start = '0;
        tick_n(40);
        total++;
        if (expire_pulse[4] !== 1'b0 || timer_not_done[4] !== 1'b1) begin
            bad++;
            $display("FAIL restart_no_old_expiry: pulse4=%b not_done4=%b want 0/1",
                     expire_pulse[4], timer_not_done[4]);
        end
        tick_n(N3 - 80 + 5);
        total++;
        if (timer_done[4:3] !== 2'b11) begin
            bad++;
            $display("FAIL concurrency_done: done[4:3]=%b want 11", timer_done[4:3]);
        end
        stop = 6'b011000;
        tick();
        stop = '0;
    endtask

    task automatic test_priority();
        int k;
        // When start and stop arrive together, start wins and the timer runs its full length.
        start = 6'b000010;
        stop  = 6'b000010;
        tick();
        k = edge_cnt;
        start = '0;
        stop  = '0;
        sb.push_back('{k + N1, 1});
        total++;
        if (timer_not_done[1] !== 1'b1) begin
            bad++;
            $display("FAIL start_over_stop: not_done1=%b want 1", timer_not_done[1]);
        end
        tick_n(N1);
        total++;
        if (timer_done[1] !== 1'b1) begin
            bad++;
            $display("FAIL start_over_stop_expiry: done1=%b want 1", timer_done[1]);
        end
        stop = 6'b000010;
        tick();
        stop = '0;

        // A stop that lands on the expiry edge sends the timer to IDLE with no pulse.
        start = 6'b000100;
        tick();
        start = '0;
        tick_n(N2 - 1);
        stop = 6'b000100;
        tick();
        stop = '0;
        total++;
        if (timer_done[2] !== 1'b0 || timer_not_done[2] !== 1'b0 || expire_pulse[2] !== 1'b0) begin
            bad++;
            $display("FAIL stop_over_expiry: done2=%b not_done2=%b pulse2=%b want 0/0/0",
                     timer_done[2], timer_not_done[2], expire_pulse[2]);
        end
        tick_n(5);

        // A start that lands on the expiry edge restarts the timer with no EXPIRED cycle.
        start = 6'b100000;
        tick();
        k = edge_cnt;
        start = '0;
        tick_n(N5 - 1);
        start = 6'b100000;
        tick();
        start = '0;
        sb.push_back('{k + 2 * N5, 5});
        total++;
        if (timer_not_done[5] !== 1'b1 || timer_done[5] !== 1'b0 || expire_pulse[5] !== 1'b0) begin
            bad++;
            $display("FAIL start_over_expiry: not_done5=%b done5=%b pulse5=%b want 1/0/0",
                     timer_not_done[5], timer_done[5], expire_pulse[5]);
        end
        tick_n(N5);
        total++;
        if (timer_done[5] !== 1'b1) begin
            bad++;
            $display("FAIL start_over_expiry_end: done5=%b want 1", timer_done[5]);
        end
        stop = 6'b100000;
        tick();
        stop = '0;
    endtask

    task automatic test_reset_mid_run();
        start = 6'h3F;
        tick();
        start = '0;
        tick_n(29);
        reset_n = 1'b0;
        start   = 6'h3F;
        tick();
        start   = '0;
        total++;
        if ({timer_done, timer_not_done, expire_pulse} !== 18'h0) begin
            bad++;
            $display("FAIL reset_mid_run: done=%h not_done=%h pulse=%h want 0",
                     timer_done, timer_not_done, expire_pulse);
        end
        reset_n = 1'b1;
        tick_n(400);
        total++;
        if ({timer_done, timer_not_done} !== 12'h0) begin
            bad++;
            $display("FAIL after_reset_idle: done=%h not_done=%h want 0", timer_done, timer_not_done);
        end
    endtask

`ifdef TIMER_FAST_SIM_EN
    task automatic test_fast_sim();
        int k;
        scale_sel = 1'b1;
        start = 6'b001000;
        tick();
        k = edge_cnt;
        start = '0;
        scale_sel = 1'b0;  // changing scale_sel mid-run must not affect the count
        sb.push_back('{k + 20, 3});
        tick_n(21);
        total++;
        if (timer_done[3] !== 1'b1) begin
            bad++;
            $display("FAIL fast_burst: done3=%b want 1", timer_done[3]);
        end
        scale_sel = 1'b1;
        start = 6'b001001;
        tick();
        k = edge_cnt;
        start = '0;
        sb.push_back('{k + 3, 0});
        sb.push_back('{k + 20, 3});
        tick_n(21);
        total++;
        if (timer_done[0] !== 1'b1) begin
            bad++;
            $display("FAIL fast_beacon: done0=%b want 1", timer_done[0]);
        end
        scale_sel = 1'b0;
        start = 6'b000001;
        tick();
        k = edge_cnt;
        start = '0;
        sb.push_back('{k + N0, 0});
        tick_n(N0 + 1);
        stop = 6'h3F;
        tick();
        stop = '0;
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        start   = '0;
        stop    = '0;
        test_reset();
        test_single_expiry();
        test_restart_concurrency();
        test_priority();
        test_reset_mid_run();
`ifdef TIMER_FAST_SIM_EN
        test_fast_sim();
`endif
        tick_n(2);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d expected pulses never seen, want 0", sb.size());
        end
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_148_4_4_timer_ctrl.md
# mod_148_4_4_timer_ctrl

Synthesizable controller for the six Clause 148.4.4 PLCA timers: beacon_timer, beacon_det_timer, invalid_beacon_timer, burst_timer, to_timer and append_commit_timer. It accepts start/stop requests from the PLCA control, data and status state machines. It converts nominal durations in ns to clock-cycle reloads and runs one down-counter per timer. It drives the IEEE-style timer_done and timer_not_done status back to those state machines, replacing the behavioural timer models in synthesis builds.

## Interface
- CLK_PERIOD_NS, 40, clock period in ns (25 MHz MII clock).
- BEACON_NS, 2000, nominal beacon_timer duration.
- BEACON_DET_NS, 2200, nominal beacon_det_timer duration.
- INVALID_BEACON_NS, 4000, nominal invalid_beacon_timer duration.
- BURST_NS, 12800, nominal burst_timer duration.
- TO_NS, 3200, nominal to_timer duration.
- APPEND_COMMIT_NS, 2200, nominal append_commit_timer duration.
- CW, 16, counter width per timer.
- clk  in  1  block clock; all logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  6  per-timer start/restart request, sampled each edge. Bit map: 0 beacon, 1 beacon_det, 2 invalid_beacon, 3 burst, 4 to, 5 append_commit.
- stop  in  6  per-timer abort request; same bit map.
- timer_done  out  6  level, timer has expired since its last start.
- timer_not_done  out  6  level, timer is running.
- expire_pulse  out  6  one-cycle strobe on the expiry edge.
- scale_sel  in  1  present only with TIMER_FAST_SIM_EN (see Configuration).

## Operation
- Each timer has its own 3-state FSM.
  - IDLE: done=0, not_done=0.
  - RUN: done=0, not_done=1.
  - EXPIRED: done=1, not_done=0.
- Reload value: N = ceil(DUR_NS / CLK_PERIOD_NS), computed at elaboration and clamped to a minimum of 1. Defaults give 50, 55, 100, 320, 80 and 55 cycles.
- Elaboration error if any N ≥ 2^CW.
- start[i] from any state: load cnt=N, go to RUN.
  - A start in RUN restarts from N; there is no accumulation.
- RUN with cnt>1: cnt decrements by 1 each cycle.
- RUN with cnt==1: go to EXPIRED, cnt=0, expire_pulse[i]=1 for that cycle.
- EXPIRED holds until start[i] or stop[i].
- stop[i] in RUN or EXPIRED: go to IDLE, cnt=0.
- Priority when signals coincide in the same cycle:
  - start over stop.
  - start over expiry: the timer restarts, with no expire_pulse and no EXPIRED cycle.
  - stop over expiry: go to IDLE, no pulse.
- Timers are fully independent, so any combination of bits may be asserted together.
- cnt never underflows or wraps.

## Timing
- Reset (reset_n=0 at an edge): all FSMs go to IDLE, cnt=0, and timer_done, timer_not_done and expire_pulse are all 0.
- Reset wins over start and stop in the same cycle. Reset during RUN aborts with no pulse.
- All outputs are registered and change only on clock edges.
- For start[i] sampled at edge k:
  - timer_not_done[i]=1 from edge k through edge k+N−1, i.e. exactly N cycles.
  - At edge k+N: timer_done[i]=1, timer_not_done[i]=0, expire_pulse[i]=1.
  - At edge k+N+1: expire_pulse[i]=0 while timer_done stays 1.
- Restart at edge j while running: expiry moves to j+N.
- Outputs never show done=1 and not_done=1 together.

## Configuration
- TIMER_FAST_SIM_EN defined:
  - Adds input scale_sel.
  - When scale_sel=1 at a start, the loaded value is max(1, N>>4), for short-duration system simulation.
  - scale_sel is sampled only at start; changing it mid-run has no effect on the running count.
- TIMER_FAST_SIM_EN undefined: the scale_sel port and its logic are absent, and the reload is always N.

## Test plan
- Reset then idle: hold reset_n=0 for 3 cycles, release, drive no starts for 400 cycles -> timer_done=6'h00, timer_not_done=6'h00, expire_pulse=6'h00 throughout.
- Single expiry: start=6'b000001 at edge k -> not_done[0]=1 for 50 cycles; done[0]=1 and one expire_pulse[0] at k+50; done[0] stays 1 until the next start.
- Restart and concurrency: start bits 3 and 4 at k, then re-start bit 4 at k+40 -> expire_pulse[4] at k+120, expire_pulse[3] at k+320, no pulse on bit 4 at k+80.
- Priority collisions:
  - start[1] and stop[1] together -> bit 1 runs a full 55 cycles.
  - stop[2] on the expiry cycle k+100 -> IDLE, no pulse.
  - start[5] on the expiry cycle -> restarts, no EXPIRED cycle.
- Reset mid-run: start=6'h3F, then reset_n=0 at k+30 -> all outputs 0 the next cycle; no pulses afterwards.
- With TIMER_FAST_SIM_EN: scale_sel=1 and start[3] -> expiry after 20 cycles. scale_sel=1 and start[0] -> expiry after 3 cycles. scale_sel=0 -> 50 cycles.
